// File: rtl/mem_pkg.sv
// Shared definitions for the data-side memory access unit: size encodings,
// the in-flight metadata entry and the byte-lane helper functions.
package mem_pkg;

  localparam logic [1:0] MEM_B = 2'd0;
  localparam logic [1:0] MEM_H = 2'd1;
  localparam logic [1:0] MEM_W = 2'd2;

  // What WB needs to know about an access once its data_ok arrives.
  typedef struct packed {
    logic       wr;
    logic [1:0] size;
    logic       unsgn;
    logic [1:0] off;
    logic       cancel;
  } meta_t;

  // Size code 3 is illegal and behaves as a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] size);
    logic [1:0] res;
    res = (size == 2'd3) ? MEM_W : size;
    return res;
  endfunction

  // Byte offset used for strobes and load shifting; half and word
  // accesses ignore the low address bits that would make them unaligned.
  function automatic logic [1:0] lane_off(input logic [1:0] size,
                                          input logic [1:0] addr_lo);
    logic [1:0] res;
    res = 2'b00;
    case (size)
      MEM_B:   res = addr_lo;
      MEM_H:   res = {addr_lo[1], 1'b0};
      default: res = 2'b00;
    endcase
    return res;
  endfunction

  // Half on an odd address, or word not on a 4-byte boundary.
  function automatic logic misaligned(input logic [1:0] size,
                                      input logic [1:0] addr_lo);
    logic res;
    res = 1'b0;
    case (size)
      MEM_B:   res = 1'b0;
      MEM_H:   res = addr_lo[0];
      default: res = (addr_lo != 2'b00);
    endcase
    return res;
  endfunction

  // Byte enables of a store for a given size and (aligned) offset.
  function automatic logic [3:0] lane_wstrb(input logic [1:0] size,
                                            input logic [1:0] off);
    logic [3:0] res;
    res = 4'b1111;
    case (size)
      MEM_B:   res = 4'b0001 << off;
      MEM_H:   res = off[1] ? 4'b1100 : 4'b0011;
      default: res = 4'b1111;
    endcase
    return res;
  endfunction

  // Replicate right-aligned store data across every lane it may land in.
  function automatic logic [31:0] lane_wdata(input logic [1:0]  size,
                                             input logic [31:0] data);
    logic [31:0] res;
    res = data;
    case (size)
      MEM_B:   res = {4{data[7:0]}};
      MEM_H:   res = {2{data[15:0]}};
      default: res = data;
    endcase
    return res;
  endfunction

  // Move the addressed lane down to bit 0 and sign/zero extend it.
  function automatic logic [31:0] load_extend(input logic [1:0]  size,
                                              input logic        unsgn,
                                              input logic [1:0]  off,
                                              input logic [31:0] rdata);
    logic [31:0] sh;
    logic [31:0] res;
    sh  = rdata >> {off, 3'b000};
    res = sh;
    case (size)
      MEM_B:   res = {{24{~unsgn & sh[7]}}, sh[7:0]};
      MEM_H:   res = {{16{~unsgn & sh[15]}}, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mem_meta_fifo.sv
// In-order metadata queue for in-flight accesses. One entry per accepted
// access; the head describes the access whose data_ok comes next. A
// broadcast cancel marks every live entry so its response is dropped.
module mem_meta_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic                       push,
  input  meta_t                      push_data,
  input  logic                       pop,
  input  logic                       cancel_all,
  output meta_t                      head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  meta_t            mem [DEPTH];
  logic [DEPTH-1:0] valid;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  assign head = mem[rd_ptr];

  // Entry storage: cancel marks live slots, pop frees the head, push fills the tail.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cancel_all && valid[i]) begin
          mem[i].cancel <= 1'b1;
        end
        if (pop && (rd_ptr == PW'(i))) begin
          valid[i] <= 1'b0;
        end
        if (push && (wr_ptr == PW'(i))) begin
          mem[i]   <= push_data;
          valid[i] <= 1'b1;
        end
      end
    end
  end

  // Pointers and occupancy; DEPTH is a power of two so the pointers wrap naturally.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (!push && pop) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// Data-side memory access unit between EX/WB and the SRAM-like data channel.
// Accepts loads/stores from EX, holds each request stable until addr_ok,
// tracks up to DEPTH accesses in order and returns extended load data to WB.
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned half/word ops raise
// ale instead of issuing a request).
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        ex_wr,
  input  logic [1:0]  ex_size,
  input  logic        ex_unsigned,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_wdata,
  input  logic        flush,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [2:0]  data_sram_size,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        wb_valid,
  output logic        wb_is_store,
  output logic [31:0] wb_rdata,
  output logic        ale,
  output logic [31:0] ale_badv
);

  localparam int CW = $clog2(DEPTH + 1);

  logic          req_r;
  logic          wr_r;
  logic [1:0]    size_r;
  logic [3:0]    wstrb_r;
  logic [31:0]   addr_r;
  logic [31:0]   wdata_r;

  logic [CW-1:0] inflight;
  meta_t         head;
  meta_t         push_meta;

  logic          data_ok_v;
  logic          room;
  logic          accept;
  logic          mis;
  logic          issue;
  logic          fire;
  logic [1:0]    size_n;
  logic [1:0]    off_n;

  // A data_ok with nothing in flight is a bridge protocol error and is ignored.
  assign data_ok_v = data_sram_data_ok && (inflight != '0);

  // A slot is free now, or one is being released by this cycle's response.
  assign room      = (inflight < CW'(DEPTH)) || data_ok_v;

  // The request register can take a new op when empty or when it is handed
  // over this cycle; a flush blocks acceptance for its own cycle.
  assign ex_ready  = !flush && (!req_r || data_sram_addr_ok) && room;
  assign accept    = ex_valid && ex_ready;

  assign size_n    = norm_size(ex_size);
  assign off_n     = lane_off(size_n, ex_addr[1:0]);

`ifdef MEM_ALIGN_CHECK_EN
  assign mis       = misaligned(size_n, ex_addr[1:0]);
`else
  assign mis       = 1'b0;
`endif

  // Misaligned ops are consumed from EX but never reach the bridge.
  assign issue     = accept && !mis;

  assign push_meta = '{wr: ex_wr, size: size_n, unsgn: ex_unsigned, off: off_n, cancel: 1'b0};

  // Request register: load on issue, otherwise drop once the bridge takes it.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      req_r   <= 1'b0;
      wr_r    <= 1'b0;
      size_r  <= 2'b00;
      wstrb_r <= 4'b0000;
      addr_r  <= '0;
      wdata_r <= '0;
    end else if (issue) begin
      req_r   <= 1'b1;
      wr_r    <= ex_wr;
      size_r  <= size_n;
      wstrb_r <= ex_wr ? lane_wstrb(size_n, off_n) : 4'b0000;
      addr_r  <= ex_addr;
      wdata_r <= lane_wdata(size_n, ex_wdata);
    end else if (data_sram_addr_ok) begin
      req_r   <= 1'b0;
    end
  end

  assign data_sram_req   = req_r;
  assign data_sram_wr    = wr_r;
  assign data_sram_size  = {1'b0, size_r};
  assign data_sram_wstrb = wstrb_r;
  assign data_sram_addr  = addr_r;
  assign data_sram_wdata = wdata_r;

  // The entry is pushed at accept time, so a flush also cancels a request
  // that is still waiting for addr_ok.
  mem_meta_fifo #(
    .DEPTH      (DEPTH)
  ) u_meta_fifo (
    .aclk       (aclk),
    .aresetn    (aresetn),
    .push       (issue),
    .push_data  (push_meta),
    .pop        (data_ok_v),
    .cancel_all (flush),
    .head       (head),
    .count      (inflight)
  );

  // A response arriving in the same cycle as a flush belongs to a flushed
  // access and is dropped like any other cancelled one.
  assign fire = data_ok_v && !head.cancel && !flush;

  // Registered one-cycle WB result.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wb_valid    <= 1'b0;
      wb_is_store <= 1'b0;
      wb_rdata    <= '0;
    end else begin
      wb_valid    <= fire;
      wb_is_store <= fire && head.wr;
      wb_rdata    <= (fire && !head.wr)
                     ? load_extend(head.size, head.unsgn, head.off, data_sram_rdata)
                     : '0;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  // Misalignment exception pulse, one cycle after the op is consumed.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ale      <= 1'b0;
      ale_badv <= '0;
    end else begin
      ale      <= accept && mis;
      ale_badv <= (accept && mis) ? ex_addr : '0;
    end
  end
`else
  assign ale      = 1'b0;
  assign ale_badv = '0;
`endif

endmodule
